// File: rtl/fastica_sample_feeder.sv
// -----------------------------------------------------------------------------
// fastica_sample_feeder
//
// Source-side streamer for the FASTICA core. Holds one frame of DEPTH
// four-channel whitened samples. On a start request it raises go_fastica and
// presents one sample per clock on z1..z4, in address order. It then keeps
// go_fastica high until fastica_busy has gone high and back low, and pulses
// frame_done for one cycle.
//
// Ports:
//   clk_fastica   in   1    system clock, rising edge
//   rst_fastica   in   1    asynchronous, active-high reset
//   wr_en         in   1    buffer write strobe (accepted in IDLE only)
//   wr_ch         in   2    channel select: 0->z1, 1->z2, 2->z3, 3->z4
//   wr_addr       in   AW   sample index
//   wr_data       in   DW   sample value
//   start         in   1    frame start request (ignored outside IDLE)
//   fastica_busy  in   1    busy flag from FASTICA
//   go_fastica    out  1    enable to FASTICA (STREAM and WAIT)
//   z1..z4        out  DW   registered sample outputs, zero when not streaming
//   feeder_busy   out  1    high in any state other than IDLE
//   frame_done    out  1    one-cycle completion pulse (DONE state)
//   wr_err        out  1    one-cycle pulse the cycle after a rejected write
// -----------------------------------------------------------------------------
module fastica_sample_feeder #(
  parameter int DW    = 26,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk_fastica,
  input  logic          rst_fastica,
  input  logic          wr_en,
  input  logic [1:0]    wr_ch,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          fastica_busy,
  output logic          go_fastica,
  output logic [DW-1:0] z1,
  output logic [DW-1:0] z2,
  output logic [DW-1:0] z3,
  output logic [DW-1:0] z4,
  output logic          feeder_busy,
  output logic          frame_done,
  output logic          wr_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_t;

  // One extra bit so idx can reach DEPTH and mark the end of the stream
  // without wrapping back to address 0.
  localparam logic [AW:0] IDX_END = (AW+1)'(DEPTH);

  state_t        state_q;
  state_t        state_d;
  logic [AW:0]   idx_q;
  logic          seen_busy_q;
  logic [DW-1:0] z_q     [4];
  logic [DW-1:0] rd_data [4];
  logic [AW-1:0] rd_addr;
  logic          wr_ok;

  logic [DW-1:0] mem_z [4][DEPTH];

  assign wr_ok = wr_en && (state_q == S_IDLE);

  // NOTE: the sample buffer has no reset on purpose: a frame loaded before a
  // reset must still be replayable afterwards, and it maps onto plain RAM.
  always_ff @(posedge clk_fastica) begin
    if (wr_ok) begin
      mem_z[wr_ch][wr_addr] <= wr_data;
    end
  end

  // Read port. In IDLE the only sample that can be launched is sample 0; a
  // write to address 0 in the same cycle as start is forwarded so the new
  // value is what gets streamed.
  assign rd_addr = (state_q == S_IDLE) ? '0 : idx_q[AW-1:0];

  always_comb begin
    for (int ch = 0; ch < 4; ch++) begin
      rd_data[ch] = mem_z[ch][rd_addr];
      if (wr_ok && (wr_addr == '0) && (wr_ch == 2'(ch))) begin
        rd_data[ch] = wr_data;
      end
    end
  end

  // State register.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_fastica or posedge rst_fastica) begin
    if (rst_fastica) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded outputs.
  // NOTE: every signal driven here gets a default first so no latch is
  // inferred on paths that do not mention it.
  always_comb begin
    state_d     = state_q;
    go_fastica  = 1'b0;
    feeder_busy = 1'b1;
    frame_done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        feeder_busy = 1'b0;
        if (start) state_d = S_STREAM;
      end
      S_STREAM: begin
        go_fastica = 1'b1;
        if (idx_q == IDX_END) state_d = S_WAIT;
      end
      S_WAIT: begin
        go_fastica = 1'b1;
        if (seen_busy_q && !fastica_busy) state_d = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: sample index, busy tracking, output registers, write error.
  always_ff @(posedge clk_fastica or posedge rst_fastica) begin
    if (rst_fastica) begin
      idx_q       <= '0;
      seen_busy_q <= 1'b0;
      wr_err      <= 1'b0;
      for (int ch = 0; ch < 4; ch++) z_q[ch] <= '0;
    end else begin
      wr_err <= wr_en && (state_q != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          seen_busy_q <= 1'b0;
          if (start) begin
            idx_q <= (AW+1)'(1);
            for (int ch = 0; ch < 4; ch++) z_q[ch] <= rd_data[ch];
          end else begin
            idx_q <= '0;
            for (int ch = 0; ch < 4; ch++) z_q[ch] <= '0;
          end
        end
        S_STREAM: begin
          if (idx_q == IDX_END) begin
            for (int ch = 0; ch < 4; ch++) z_q[ch] <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
            for (int ch = 0; ch < 4; ch++) z_q[ch] <= rd_data[ch];
          end
        end
        S_WAIT: begin
          // Busy is only tracked once streaming is over, so a frame always
          // spends at least two cycles in WAIT.
          if (fastica_busy) seen_busy_q <= 1'b1;
          for (int ch = 0; ch < 4; ch++) z_q[ch] <= '0;
        end
        S_DONE: begin
          seen_busy_q <= 1'b0;
          idx_q       <= '0;
          for (int ch = 0; ch < 4; ch++) z_q[ch] <= '0;
        end
        default: begin
          idx_q       <= '0;
          seen_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign z1 = z_q[0];
  assign z2 = z_q[1];
  assign z3 = z_q[2];
  assign z4 = z_q[3];

endmodule

// File: doc/fastica_sample_feeder.md
# fastica_sample_feeder

Source-side streamer for the FASTICA core. It buffers one frame of 128 four-channel whitened samples (z1..z4, 26-bit signed) written by the upstream whitening stage or host. On a start request it raises go_fastica and presents exactly one sample per clock, in address order, on the z1..z4 inputs of FASTICA. It then holds go_fastica until the core's fastica_busy completes a high-then-low cycle, and signals frame completion.

## Interface
- DW, 26, sample width (signed two's complement)
- DEPTH, 128, samples per frame per channel
- AW, 7, address width (log2 DEPTH)

Ports:
- clk_fastica  in  1  system clock, all logic on rising edge
- rst_fastica  in  1  asynchronous, active-high reset
- wr_en  in  1  buffer write strobe
- wr_ch  in  2  channel select: 0→z1, 1→z2, 2→z3, 3→z4
- wr_addr  in  AW  sample index
- wr_data  in  DW  sample value
- start  in  1  frame start request (level sampled per cycle)
- fastica_busy  in  1  busy flag from FASTICA
- go_fastica  out  1  enable to FASTICA
- z1, z2, z3, z4  out  DW each  registered sample outputs
- feeder_busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle completion pulse
- wr_err  out  1  one-cycle pulse when a write is rejected

## Operation
- Storage: four DEPTH×DW arrays, one per channel. The arrays are not cleared by reset, so their contents survive rst_fastica.
- Writes are accepted only in IDLE. A wr_en in any other state is dropped, and wr_err pulses on the next cycle.
- States:
  - IDLE: go_fastica=0, z*=0. When start=1, go to STREAM. Register z*<=mem[0], idx<=1, go_fastica<=1.
  - STREAM: each cycle, z*<=mem[idx] and idx<=idx+1. When the cycle that presents sample DEPTH-1 ends, go to WAIT. z*<=0, go_fastica stays 1.
  - WAIT: go_fastica=1, z*=0. Set seen_busy when fastica_busy=1. When seen_busy=1 and fastica_busy=0, go to DONE.
  - DONE: for one cycle, go_fastica=0 and frame_done=1, then go to IDLE.
- Simultaneous write and start in IDLE: the write commits first. A same-cycle write to address 0 is therefore visible as sample 0.
- start outside IDLE is ignored. It is not queued.
- Samples pass through unmodified, with no saturation or sign manipulation.
- idx does not wrap during STREAM. Streaming always ends after exactly DEPTH samples.

## Timing
- Reset values: go_fastica=0, z1..z4=0, feeder_busy=0, frame_done=0, wr_err=0, state=IDLE, idx=0, seen_busy=0. Reset takes effect immediately, mid-frame included.
- Start latency: with start high at edge E0, go_fastica=1 and z*=sample[0] are visible after E0.
- Streaming: sample k is visible for the single cycle following edge E0+k, for k=0..DEPTH-1. go_fastica is high continuously from E0 until DONE.
- After E0+DEPTH, the feeder is in WAIT with z*=0.
- Completion: if fastica_busy falls, having been seen high, before edge Ef, the state is DONE after Ef (frame_done=1, go_fastica=0) and IDLE after Ef+1.
- Minimum frame length is DEPTH+3 cycles from start to IDLE.
- If fastica_busy never rises, the feeder stays in WAIT indefinitely. Recovery is by rst_fastica.
- wr_err asserts exactly one cycle after each rejected write.

## Test plan
- Reset mid-STREAM: assert rst_fastica asynchronously at sample 60 → go_fastica, z*, feeder_busy fall to 0 without waiting for a clock edge. A subsequent start replays the retained buffer from sample 0.
- Load and stream: write z1[k]=k, z2[k]=-k, z3[k]=26'h1FFFFFF, z4[k]=26'h2000000 for k=0..127, then pulse start.
  - go_fastica rises one cycle after start.
  - z1 reads 0,1,…,127 on consecutive cycles, z2 reads 0,-1,…,-127, and z3/z4 are constant.
  - z*=0 on the 129th cycle.
- Busy handshake: fastica_busy rises 5 cycles into STREAM and falls 200 cycles after start → frame_done pulses once, 1 cycle after busy falls. go_fastica=0 in that cycle, then IDLE and feeder_busy=0.
- Busy never asserted: hold fastica_busy=0 → the feeder stays in WAIT with go_fastica=1 for 1000 cycles and frame_done is never asserted.
- Rejected write and start: wr_en to z2[5] and start during STREAM → wr_err pulses once and z2[5] is unchanged on the next frame. The current frame is unaffected and no second frame follows.
- Same-cycle write/start: in IDLE, write z1[0]=26'h0000ABC together with start → first streamed z1=26'h0000ABC.
